// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path (and, later, the receive side).
//   - UART_BYTE_WIDTH : width of one UART character
//   - uart_byte_t     : one UART character
//   - DRAIN_*         : encodings of the FIFO drain state machine in uart_tx_fifo.
//                       They are plain constants so existing code can compare
//                       against the raw 2-bit values.
package uart_pkg;

    localparam int UART_BYTE_WIDTH = 8;

    typedef logic [UART_BYTE_WIDTH-1:0] uart_byte_t;

    localparam logic [1:0] DRAIN_IDLE = 2'd0;
    localparam logic [1:0] DRAIN_SEND = 2'd1;
    localparam logic [1:0] DRAIN_WAIT = 2'd2;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
// Bundles the CPU write path and the uart_tx handshake of uart_tx_fifo.
//   wr_data   : byte to enqueue
//   wr_strobe : one-cycle pulse per byte to enqueue
//   ovf_clear : clears the sticky overflow flag
//   full      : FIFO holds 2**DEPTH_LOG2 bytes
//   empty     : FIFO holds no bytes
//   count     : bytes queued, excluding the byte already handed to uart_tx
//   overflow  : sticky, a write arrived while full
//   tx_data   : byte presented to uart_tx
//   tx_strobe : one-cycle start pulse to uart_tx
//   tx_busy   : busy flag from uart_tx
// Modports:
//   master : the surrounding system (CPU side plus uart_tx)
//   slave  : uart_tx_fifo itself
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    import uart_pkg::*;

    uart_byte_t            wr_data;
    logic                  wr_strobe;
    logic                  ovf_clear;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    uart_byte_t            tx_data;
    logic                  tx_strobe;
    logic                  tx_busy;

    modport master (
        output wr_data,
        output wr_strobe,
        output ovf_clear,
        output tx_busy,
        input  full,
        input  empty,
        input  count,
        input  overflow,
        input  tx_data,
        input  tx_strobe
    );

    modport slave (
        input  wr_data,
        input  wr_strobe,
        input  ovf_clear,
        input  tx_busy,
        output full,
        output empty,
        output count,
        output overflow,
        output tx_data,
        output tx_strobe
    );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with an explicit occupancy counter. Kept generic so the
// receive side can reuse it.
//   clk       : clock
//   rst_n     : synchronous active-low reset (pointers and count only)
//   push      : enqueue push_data; ignored when full unless a pop happens too
//   push_data : data to enqueue
//   pop       : dequeue head entry; ignored when empty
//   pop_data  : current head entry (valid while !empty)
//   full      : 2**DEPTH_LOG2 entries held
//   empty     : no entries held
//   count     : number of entries held
module sync_fifo import uart_pkg::*; #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = UART_BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]        mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     level;
    logic                    do_push;
    logic                    do_pop;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; level disambiguates full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign count    = level;
    assign full     = (level == FULL_COUNT);
    assign empty    = (level == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte queue between the CPU write path and uart_tx. Software can burst-write
// a string; a small drain state machine feeds the bytes to uart_tx one at a
// time using its data/strobe/busy handshake.
//   i_clk     : system clock
//   i_rst_n   : synchronous active-low reset
//   bus       : uart_tx_fifo_if.slave (write path, status, uart_tx handshake)
// Parameter DEPTH_LOG2 (1..8) sets the queue depth to 2**DEPTH_LOG2 bytes and
// must match the DEPTH_LOG2 of the connected interface.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    uart_tx_fifo_if.slave     bus
);

    logic [1:0]            state;
    logic                  pop;
    uart_byte_t            head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  overflow_q;
    logic                  tx_strobe_q;
    uart_byte_t            tx_data_q;

    // empty is registered, so a byte written this cycle is only eligible for
    // popping from the next cycle on.
    assign pop = (state == DRAIN_IDLE) && !fifo_empty && !bus.tx_busy;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (UART_BYTE_WIDTH)
    ) fifo (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .push       (bus.wr_strobe),
        .push_data  (bus.wr_data),
        .pop        (pop),
        .pop_data   (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // A write is only lost when the FIFO is full and no pop frees a slot.
    // Setting wins over clearing so a drop is never hidden by a clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            overflow_q <= 1'b0;
        end else if (bus.wr_strobe && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end else if (bus.ovf_clear) begin
            overflow_q <= 1'b0;
        end
    end

    // SEND covers the cycle where uart_tx has sampled the strobe but has not
    // yet raised busy; WAIT then holds until busy falls. After a reset the
    // machine still waits for busy low in IDLE, because uart_tx is not reset
    // and may be finishing a byte.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= DRAIN_IDLE;
            tx_strobe_q <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            case (state)
                DRAIN_IDLE: begin
                    if (pop) begin
                        tx_data_q   <= head;
                        tx_strobe_q <= 1'b1;
                        state       <= DRAIN_SEND;
                    end
                end
                DRAIN_SEND: begin
                    tx_strobe_q <= 1'b0;
                    state       <= DRAIN_WAIT;
                end
                DRAIN_WAIT: begin
                    if (!bus.tx_busy) begin
                        state <= DRAIN_IDLE;
                    end
                end
                default: begin
                    tx_strobe_q <= 1'b0;
                    state       <= DRAIN_IDLE;
                end
            endcase
        end
    end

    assign bus.full      = fifo_full;
    assign bus.empty     = fifo_empty;
    assign bus.count     = fifo_count;
    assign bus.overflow  = overflow_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_strobe = tx_strobe_q;

endmodule
